mul_accumulator: RTL and testbench

- Sequential accumulate stage directly downstream of the 16-bit Booth multiplier.
- Consumes a burst of signed 16-bit products plus the multiplier overflow flag, one per accepted beat.
- Sums the burst into a saturating signed accumulator and presents the total with sticky status flags through a valid/ready output handshake.
- Sits between the ALU multiply path and the result writeback.

---
 rtl/mul_accumulator.sv | 168 ++++++++++++++++
 tb/tb_mul_accumulator.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_accumulator.sv
// Saturating signed accumulate stage for a burst of 16-bit multiplier products.
// Accepts a burst of len beats, then holds the sum and sticky flags until downstream takes it.
module mul_accumulator #(
    parameter int ACC_W = 18,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_prod,
    input  logic             in_ov,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_acc,
    output logic             out_sat,
    output logic             out_ov,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [ACC_W-1:0] ACC_MAX  = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN  = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t             state_r;
    state_t             state_nxt_s;
    logic [ACC_W-1:0]   acc_r;
    logic [CNT_W-1:0]   cnt_r;
    logic               sat_r;
    logic               ov_r;
    logic [ACC_W:0]     sat_res_s;
    logic               accept_s;

    // Returns {clamp_flag, result}; one guard bit detects overflow of the signed sum.
    function automatic logic [ACC_W:0] sat_add(input logic [ACC_W-1:0] a,
                                               input logic [15:0] p);
        logic [ACC_W:0] sum;
        sum = {a[ACC_W-1], a} + {{(ACC_W-15){p[15]}}, p};
        if (sum[ACC_W] != sum[ACC_W-1]) begin
            if (sum[ACC_W]) begin
                sat_add = {1'b1, ACC_MIN};
            end else begin
                sat_add = {1'b1, ACC_MAX};
            end
        end else begin
            sat_add = {1'b0, sum[ACC_W-1:0]};
        end
    endfunction

    // Saturating sum of the running total and the current beat
    always_comb begin
        sat_res_s = sat_add(acc_r, in_prod);
        accept_s  = in_valid && (state_r == RUN);
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_nxt_s = (len == CNT_ZERO) ? DONE : RUN;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RUN: begin
                if (accept_s && (cnt_r == CNT_ONE)) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = DONE;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Handshake and status outputs decoded from state
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state_r)
            IDLE: begin
                in_ready  = 1'b0;
                out_valid = 1'b0;
                busy      = 1'b0;
            end
            RUN: begin
                in_ready  = 1'b1;
                out_valid = 1'b0;
                busy      = 1'b1;
            end
            DONE: begin
                in_ready  = 1'b0;
                out_valid = 1'b1;
                busy      = 1'b1;
            end
            default: begin
                in_ready  = 1'b0;
                out_valid = 1'b0;
                busy      = 1'b0;
            end
        endcase
    end

    // Accumulator, beat counter and sticky flags; values persist in IDLE until the next start
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_r <= {ACC_W{1'b0}};
            cnt_r <= CNT_ZERO;
            sat_r <= 1'b0;
            ov_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        acc_r <= {ACC_W{1'b0}};
                        cnt_r <= len;
                        sat_r <= 1'b0;
                        ov_r  <= 1'b0;
                    end
                end
                RUN: begin
                    if (accept_s) begin
                        acc_r <= sat_res_s[ACC_W-1:0];
                        cnt_r <= cnt_r - CNT_ONE;
                        sat_r <= sat_r | sat_res_s[ACC_W];
                        ov_r  <= ov_r | in_ov;
                    end
                end
                default: begin
                    acc_r <= acc_r;
                end
            endcase
        end
    end

    assign out_acc = acc_r;
    assign out_sat = sat_r;
    assign out_ov  = ov_r;

endmodule

// File: tb/tb_mul_accumulator.sv
// Self-checking bench for mul_accumulator: vector table, hand-written corner sequences,
// and randomized bursts against an integer-arithmetic reference model.
module tb_mul_accumulator;

    localparam int ACC_W   = 18;
    localparam int CNT_W   = 4;
    localparam int ACC_MAX = (1 << (ACC_W - 1)) - 1;
    localparam int ACC_MIN = -(1 << (ACC_W - 1));

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [CNT_W-1:0] len;
    logic             in_valid;
    logic             in_ready;
    logic [15:0]      in_prod;
    logic             in_ov;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_acc;
    logic             out_sat;
    logic             out_ov;
    logic             busy;

    int checks   = 0;
    int failures = 0;

    logic signed [15:0] bp [16];
    logic               bo [16];

    typedef struct {
        int          len;
        logic [5:0][15:0] p;
        logic [5:0]  ovm;
        int          eacc;
        int          esat;
        int          eov;
    } vec_t;

    vec_t vec [6];

    mul_accumulator #(.ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .start(start), .len(len),
        .in_valid(in_valid), .in_ready(in_ready), .in_prod(in_prod), .in_ov(in_ov),
        .out_valid(out_valid), .out_ready(out_ready), .out_acc(out_acc),
        .out_sat(out_sat), .out_ov(out_ov), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int acc_now();
        return int'($signed(out_acc));
    endfunction

    // Reference: plain integer sum with clamping after every beat
    task automatic model(input int n, output int acc, output int sat, output int ov);
        acc = 0; sat = 0; ov = 0;
        for (int i = 0; i < n; i++) begin
            acc = acc + int'(bp[i]);
            if (acc > ACC_MAX) begin acc = ACC_MAX; sat = 1; end
            if (acc < ACC_MIN) begin acc = ACC_MIN; sat = 1; end
            if (bo[i]) ov = 1;
        end
    endtask

    // Runs one burst from IDLE using bp/bo, optionally with idle gaps and stray starts
    task automatic do_burst(input string name, input int n, input bit gaps,
                            input int eacc, input int esat, input int eov);
        start = 1'b1; len = n[CNT_W-1:0];
        tick();
        start = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                int g = $urandom_range(0, 2);
                repeat (g) begin
                    in_valid = 1'b0; in_prod = 16'($urandom); in_ov = 1'b1;
                    start = 1'($urandom); len = 4'd0;
                    tick();
                    start = 1'b0;
                end
            end
            chk({name, ".in_ready"}, int'(in_ready), 1);
            in_valid = 1'b1; in_prod = bp[i]; in_ov = bo[i];
            tick();
            in_valid = 1'b0; in_ov = 1'b0;
        end
        chk({name, ".out_valid"}, int'(out_valid), 1);
        chk({name, ".in_ready_done"}, int'(in_ready), 0);
        chk({name, ".acc"}, acc_now(), eacc);
        chk({name, ".sat"}, int'(out_sat), esat);
        chk({name, ".ov"}, int'(out_ov), eov);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({name, ".valid_drop"}, int'(out_valid), 0);
        chk({name, ".busy_drop"}, int'(busy), 0);
        chk({name, ".acc_kept"}, acc_now(), eacc);
    endtask

    task automatic set_vec(input int idx, input int n,
                           input logic [15:0] p0, input logic [15:0] p1, input logic [15:0] p2,
                           input logic [15:0] p3, input logic [15:0] p4, input logic [15:0] p5,
                           input logic [5:0] ovm, input int eacc, input int esat, input int eov);
        vec[idx].len = n;
        vec[idx].p[0] = p0; vec[idx].p[1] = p1; vec[idx].p[2] = p2;
        vec[idx].p[3] = p3; vec[idx].p[4] = p4; vec[idx].p[5] = p5;
        vec[idx].ovm = ovm; vec[idx].eacc = eacc; vec[idx].esat = esat; vec[idx].eov = eov;
    endtask

    initial begin
        int ra, rs, ro, n;
        logic [15:0] pat;
        logic [6:0] vpat;
        int nacc;

        set_vec(0, 3, 16'd100, 16'hFFCE, 16'd7, 16'd0, 16'd0, 16'd0, 6'b000000, 57, 0, 0);
        set_vec(1, 5, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'd0, 6'b000000, 131071, 1, 0);
        set_vec(2, 5, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'd0, 6'b000000, -131072, 1, 0);
        set_vec(3, 0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 6'b000000, 0, 0, 0);
        set_vec(4, 6, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'hFF9C, 6'b000000, 130971, 1, 0);
        set_vec(5, 3, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'd0, 16'd0, 16'd0, 6'b000100, -3, 0, 1);

        rst = 1'b1; start = 1'b0; len = 4'd0; in_valid = 1'b0; in_prod = 16'd0;
        in_ov = 1'b0; out_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
        chk("reset.in_ready", int'(in_ready), 0);
        chk("reset.out_valid", int'(out_valid), 0);
        chk("reset.busy", int'(busy), 0);
        chk("reset.acc", acc_now(), 0);
        chk("reset.flags", int'({out_sat, out_ov}), 0);
        tick();
        chk("idle_hold.busy", int'(busy), 0);

        for (int v = 0; v < 6; v++) begin
            for (int i = 0; i < vec[v].len; i++) begin
                bp[i] = vec[v].p[i]; bo[i] = vec[v].ovm[i];
            end
            do_burst($sformatf("vec%0d", v), vec[v].len, 1'b0, vec[v].eacc, vec[v].esat, vec[v].eov);
        end

        // Gapped beats, stray starts in RUN, then output back-pressure and start on handoff
        start = 1'b1; len = 4'd4;
        tick();
        vpat = 7'b1011001;
        nacc = 0;
        for (int c = 0; c < 7; c++) begin
            in_valid = vpat[c]; in_prod = 16'd10;
            in_ov = (vpat[c] && nacc == 1) ? 1'b1 : 1'b0;
            start = ~vpat[c]; len = 4'd0;
            if (vpat[c]) nacc++;
            tick();
        end
        in_valid = 1'b0; in_ov = 1'b0;
        chk("gap.out_valid", int'(out_valid), 1);
        chk("gap.acc", acc_now(), 40);
        chk("gap.ov", int'(out_ov), 1);
        chk("gap.sat", int'(out_sat), 0);
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1; in_prod = 16'd5; in_ov = 1'b1; start = 1'b1; len = 4'd0;
            tick();
            chk("hold.out_valid", int'(out_valid), 1);
            chk("hold.in_ready", int'(in_ready), 0);
            chk("hold.acc", acc_now(), 40);
            chk("hold.flags", int'({out_sat, out_ov}), 1);
        end
        in_valid = 1'b0; in_ov = 1'b0;
        start = 1'b1; len = 4'd5; out_ready = 1'b1;
        tick();
        start = 1'b0; out_ready = 1'b0;
        chk("handoff.out_valid", int'(out_valid), 0);
        tick();
        chk("handoff_start_ignored.busy", int'(busy), 0);
        chk("handoff_start_ignored.acc", acc_now(), 40);

        // Back-to-back: start immediately after the return to IDLE, flags cleared
        bp[0] = 16'sd3; bo[0] = 1'b0;
        do_burst("b2b_first", 1, 1'b0, 3, 0, 0);
        bp[0] = -16'sd8; bo[0] = 1'b0; bp[1] = 16'sd2; bo[1] = 1'b0;
        do_burst("b2b_second", 2, 1'b0, -6, 0, 0);

        // Reset mid-burst discards the partial sum
        start = 1'b1; len = 4'd4;
        tick();
        start = 1'b0;
        in_valid = 1'b1; in_prod = 16'd10; in_ov = 1'b1;
        tick();
        in_prod = 16'd20;
        tick();
        in_valid = 1'b0; in_ov = 1'b0;
        chk("midburst.acc", acc_now(), 30);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_mid.busy", int'(busy), 0);
        chk("rst_mid.acc", acc_now(), 0);
        chk("rst_mid.flags", int'({out_sat, out_ov}), 0);
        chk("rst_mid.valid", int'(out_valid), 0);
        bp[0] = -16'sd1; bo[0] = 1'b0;
        do_burst("after_rst", 1, 1'b0, -1, 0, 0);
        chk("after_rst.raw", int'(out_acc), 32'h3FFFF);

        // Randomized bursts against the reference model
        for (int t = 0; t < 40; t++) begin
            n = $urandom_range(0, 15);
            for (int i = 0; i < n; i++) begin
                case ($urandom_range(0, 3))
                    0: pat = 16'h7FFF - 16'($urandom_range(0, 255));
                    1: pat = 16'h8000 + 16'($urandom_range(0, 255));
                    default: pat = 16'($urandom);
                endcase
                bp[i] = pat;
                bo[i] = ($urandom_range(0, 7) == 0);
            end
            model(n, ra, rs, ro);
            do_burst($sformatf("rand%0d", t), n, 1'b1, ra, rs, ro);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
